// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the unified-memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_F = 2'd1,
    BUSY_M = 2'd2
  } arb_state_t;

  // Counter width able to hold MEMLATENCY-1 (and at least one bit).
  function automatic int arb_cntw(input int latency);
    return (latency < 2) ? 1 : $clog2(latency + 1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_access_timer.sv
// Loadable down-counter timing one memory access; done is high at zero.
module access_timer #(
  parameter int MEMLATENCY = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic done
);
  import mem_arb_pkg::*;

  localparam int ARB_CNTW = arb_cntw(MEMLATENCY);
  localparam logic [ARB_CNTW-1:0] LOAD_VAL = ARB_CNTW'(MEMLATENCY - 1);

  logic [ARB_CNTW-1:0] cnt_d, cnt_q;

  // Load on grant, otherwise count down and park at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = LOAD_VAL;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - ARB_CNTW'(1);
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-ported unified memory between fetch (F) and
// memory stage (M); holds the port for MEMLATENCY cycles per access.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | port free; grant M or F (F wins if M was granted last)
// BUSY_F | fetch access in flight, port outputs held
// BUSY_M | M-stage read/write in flight, port outputs held
module mem_port_arbiter #(
  parameter int DATAWIDTH  = 32,
  parameter int ADDRWIDTH  = 32,
  parameter int MEMLATENCY = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fetchReqF,
  input  logic [ADDRWIDTH-1:0] fetchAddrF,
  output logic [DATAWIDTH-1:0] fetchDataF,
  output logic                 fetchValidF,
  input  logic                 memReqM,
  input  logic                 memWriteM,
  input  logic [ADDRWIDTH-1:0] memAddrM,
  input  logic [DATAWIDTH-1:0] memWdataM,
  output logic [DATAWIDTH-1:0] memRdataM,
  output logic                 memValidM,
  output logic                 stallF,
  output logic                 stallM,
  output logic                 portEn,
  output logic                 portWe,
  output logic [ADDRWIDTH-1:0] portAddr,
  output logic [DATAWIDTH-1:0] portWdata,
  input  logic [DATAWIDTH-1:0] portRdata
);
  import mem_arb_pkg::*;

  arb_state_t           state_d, state_q;
  logic                 last_m_d, last_m_q;
  logic                 port_en_d, port_en_q;
  logic                 port_we_d, port_we_q;
  logic [ADDRWIDTH-1:0] port_addr_d, port_addr_q;
  logic [DATAWIDTH-1:0] port_wdata_d, port_wdata_q;
  logic [DATAWIDTH-1:0] fetch_data_d, fetch_data_q;
  logic [DATAWIDTH-1:0] mem_rdata_d, mem_rdata_q;
  logic                 fetch_valid_d, fetch_valid_q;
  logic                 mem_valid_d, mem_valid_q;
  logic                 timer_load, timer_done;
  logic                 elig_f, elig_m, grant_f, grant_m;

  access_timer #(.MEMLATENCY(MEMLATENCY)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .load (timer_load),
    .done (timer_done)
  );

  // A requester sitting in its own valid cycle has just been served and
  // must not be re-granted; that is what lets the other side in.
  assign elig_f  = fetchReqF & ~fetch_valid_q;
  assign elig_m  = memReqM & ~mem_valid_q;
  assign grant_m = elig_m & ~(last_m_q & elig_f);
  assign grant_f = elig_f & ~grant_m;

  // Next-state, port set-up on grant, and completion handling.
  always_comb begin
    state_d       = state_q;
    last_m_d      = last_m_q;
    port_en_d     = port_en_q;
    port_we_d     = port_we_q;
    port_addr_d   = port_addr_q;
    port_wdata_d  = port_wdata_q;
    fetch_data_d  = fetch_data_q;
    mem_rdata_d   = mem_rdata_q;
    fetch_valid_d = 1'b0;
    mem_valid_d   = 1'b0;
    timer_load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_m) begin
          state_d      = BUSY_M;
          last_m_d     = 1'b1;
          timer_load   = 1'b1;
          port_en_d    = 1'b1;
          port_we_d    = memWriteM;
          port_addr_d  = memAddrM;
          port_wdata_d = memWdataM;
        end else if (grant_f) begin
          state_d      = BUSY_F;
          last_m_d     = 1'b0;
          timer_load   = 1'b1;
          port_en_d    = 1'b1;
          port_we_d    = 1'b0;
          port_addr_d  = fetchAddrF;
          port_wdata_d = '0;
        end
      end
      BUSY_F: begin
        if (timer_done) begin
          state_d       = IDLE;
          fetch_data_d  = portRdata;
          fetch_valid_d = 1'b1;
          port_en_d     = 1'b0;
          port_we_d     = 1'b0;
          port_addr_d   = '0;
          port_wdata_d  = '0;
        end
      end
      BUSY_M: begin
        if (timer_done) begin
          state_d     = IDLE;
          if (!port_we_q) mem_rdata_d = portRdata;
          mem_valid_d  = 1'b1;
          port_en_d    = 1'b0;
          port_we_d    = 1'b0;
          port_addr_d  = '0;
          port_wdata_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset abandons any in-flight access.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      last_m_q      <= 1'b0;
      port_en_q     <= 1'b0;
      port_we_q     <= 1'b0;
      port_addr_q   <= '0;
      port_wdata_q  <= '0;
      fetch_data_q  <= '0;
      mem_rdata_q   <= '0;
      fetch_valid_q <= 1'b0;
      mem_valid_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_m_q      <= last_m_d;
      port_en_q     <= port_en_d;
      port_we_q     <= port_we_d;
      port_addr_q   <= port_addr_d;
      port_wdata_q  <= port_wdata_d;
      fetch_data_q  <= fetch_data_d;
      mem_rdata_q   <= mem_rdata_d;
      fetch_valid_q <= fetch_valid_d;
      mem_valid_q   <= mem_valid_d;
    end
  end

  assign fetchDataF  = fetch_data_q;
  assign fetchValidF = fetch_valid_q;
  assign memRdataM   = mem_rdata_q;
  assign memValidM   = mem_valid_q;
  assign portEn      = port_en_q;
  assign portWe      = port_we_q;
  assign portAddr    = port_addr_q;
  assign portWdata   = port_wdata_q;
  assign stallF      = fetchReqF & ~fetch_valid_q;
  assign stallM      = memReqM & ~mem_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (MEMLATENCY=2) with a read-data
// scoreboard per requester.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetchReqF;
  logic [31:0] fetchAddrF;
  logic [31:0] fetchDataF;
  logic        fetchValidF;
  logic        memReqM;
  logic        memWriteM;
  logic [31:0] memAddrM;
  logic [31:0] memWdataM;
  logic [31:0] memRdataM;
  logic        memValidM;
  logic        stallF;
  logic        stallM;
  logic        portEn;
  logic        portWe;
  logic [31:0] portAddr;
  logic [31:0] portWdata;
  logic [31:0] portRdata;

  int checks = 0;
  int errors = 0;
  logic [31:0] fq[$];
  logic [31:0] mq[$];
  logic [31:0] last_mrd;

  mem_port_arbiter #(.DATAWIDTH(32), .ADDRWIDTH(32), .MEMLATENCY(2)) dut (
    .clk(clk), .rst(rst),
    .fetchReqF(fetchReqF), .fetchAddrF(fetchAddrF),
    .fetchDataF(fetchDataF), .fetchValidF(fetchValidF),
    .memReqM(memReqM), .memWriteM(memWriteM), .memAddrM(memAddrM),
    .memWdataM(memWdataM), .memRdataM(memRdataM), .memValidM(memValidM),
    .stallF(stallF), .stallM(stallM),
    .portEn(portEn), .portWe(portWe), .portAddr(portAddr),
    .portWdata(portWdata), .portRdata(portRdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rd_model(input logic [31:0] a);
    if (a == 32'h10) return 32'hDEADBEEF;
    return (a * 32'h0101_0101) ^ 32'hC0DE_0000;
  endfunction

  assign portRdata = portEn ? rd_model(portAddr) : 32'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_port(input string tag, input logic en, input logic [31:0] addr);
    chk({tag, "_en"}, {31'b0, portEn}, {31'b0, en});
    chk({tag, "_addr"}, portAddr, addr);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every valid pulse must match the oldest pushed expectation.
  always @(negedge clk) begin
    if (fetchValidF === 1'b1) begin
      if (fq.size() == 0) chk("fetch_unexpected_valid", 32'd1, 32'd0);
      else chk("fetch_data_sb", fetchDataF, fq.pop_front());
    end
    if (memValidM === 1'b1) begin
      if (mq.size() == 0) chk("mem_unexpected_valid", 32'd1, 32'd0);
      else chk("mem_data_sb", memRdataM, mq.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; fetchReqF = 1'b0; fetchAddrF = '0; memReqM = 1'b0;
    memWriteM = 1'b0; memAddrM = '0; memWdataM = '0; last_mrd = '0;

    // Reset
    repeat (2) @(posedge clk);
    #2;
    chk("rst_state", {30'b0, dut.state_q}, {30'b0, IDLE});
    chk("rst_fdata", fetchDataF, 32'h0);
    chk("rst_fvalid", {31'b0, fetchValidF}, 32'h0);
    chk("rst_mdata", memRdataM, 32'h0);
    chk("rst_mvalid", {31'b0, memValidM}, 32'h0);
    chk("rst_stallF", {31'b0, stallF}, 32'h0);
    chk("rst_stallM", {31'b0, stallM}, 32'h0);
    chk("rst_we", {31'b0, portWe}, 32'h0);
    chk("rst_wdata", portWdata, 32'h0);
    chk_port("rst_port", 1'b0, 32'h0);
    rst = 1'b0;
    tick();

    // Single fetch
    tick();
    fetchReqF = 1'b1; fetchAddrF = 32'h10; fq.push_back(32'hDEADBEEF);
    #1;
    chk("sf_stallF_c0", {31'b0, stallF}, 32'h1);
    chk_port("sf_c0", 1'b0, 32'h0);
    for (int c = 1; c <= 2; c++) begin
      tick(); #1;
      chk_port("sf_busy", 1'b1, 32'h10);
      chk("sf_stallF_busy", {31'b0, stallF}, 32'h1);
    end
    tick(); #1;
    chk("sf_fvalid_c3", {31'b0, fetchValidF}, 32'h1);
    chk("sf_fdata_c3", fetchDataF, 32'hDEADBEEF);
    chk("sf_stallF_c3", {31'b0, stallF}, 32'h0);
    chk_port("sf_c3", 1'b0, 32'h0);
    fetchReqF = 1'b0;
    tick(); #1;
    chk("sf_fvalid_c4", {31'b0, fetchValidF}, 32'h0);

    // Contention, lastM=0: M first, F in M's valid cycle
    tick();
    fetchReqF = 1'b1; fetchAddrF = 32'h20; fq.push_back(rd_model(32'h20));
    memReqM = 1'b1; memAddrM = 32'h30; mq.push_back(rd_model(32'h30));
    last_mrd = rd_model(32'h30);
    #1;
    chk("ct_stallM_c0", {31'b0, stallM}, 32'h1);
    for (int c = 1; c <= 2; c++) begin
      tick(); #1;
      chk_port("ct_m_busy", 1'b1, 32'h30);
      chk("ct_stallF_m", {31'b0, stallF}, 32'h1);
    end
    tick(); #1;
    chk("ct_mvalid_c3", {31'b0, memValidM}, 32'h1);
    chk("ct_stallM_c3", {31'b0, stallM}, 32'h0);
    chk("ct_stallF_c3", {31'b0, stallF}, 32'h1);
    memReqM = 1'b0;
    for (int c = 4; c <= 5; c++) begin
      tick(); #1;
      chk_port("ct_f_busy", 1'b1, 32'h20);
      chk("ct_stallF_f", {31'b0, stallF}, 32'h1);
      chk("ct_mvalid_once", {31'b0, memValidM}, 32'h0);
    end
    tick(); #1;
    chk("ct_fvalid_c6", {31'b0, fetchValidF}, 32'h1);
    chk("ct_stallF_c6", {31'b0, stallF}, 32'h0);
    fetchReqF = 1'b0;

    // Starvation guard: M continuously requesting, F waiting
    tick();
    fetchReqF = 1'b1; fetchAddrF = 32'h24; fq.push_back(rd_model(32'h24));
    memReqM = 1'b1; memAddrM = 32'h34; mq.push_back(rd_model(32'h34));
    for (int c = 1; c <= 2; c++) begin
      tick(); #1;
      chk_port("sg_m1", 1'b1, 32'h34);
    end
    tick();
    memAddrM = 32'h38; mq.push_back(rd_model(32'h38)); last_mrd = rd_model(32'h38);
    #1;
    chk("sg_mvalid_c3", {31'b0, memValidM}, 32'h1);
    for (int c = 4; c <= 5; c++) begin
      tick(); #1;
      chk_port("sg_f", 1'b1, 32'h24);
      chk("sg_stallM_wait", {31'b0, stallM}, 32'h1);
    end
    tick(); #1;
    chk("sg_fvalid_c6", {31'b0, fetchValidF}, 32'h1);
    chk("sg_mvalid_c6", {31'b0, memValidM}, 32'h0);
    fetchReqF = 1'b0;
    for (int c = 7; c <= 8; c++) begin
      tick(); #1;
      chk_port("sg_m2", 1'b1, 32'h38);
    end
    tick(); #1;
    chk("sg_mvalid_c9", {31'b0, memValidM}, 32'h1);
    memReqM = 1'b0;
    tick();

    // Simultaneous requests with lastM=1: F wins
    tick();
    fetchReqF = 1'b1; fetchAddrF = 32'h28; fq.push_back(rd_model(32'h28));
    memReqM = 1'b1; memAddrM = 32'h3C; mq.push_back(rd_model(32'h3C));
    last_mrd = rd_model(32'h3C);
    for (int c = 1; c <= 2; c++) begin
      tick(); #1;
      chk_port("tb_f", 1'b1, 32'h28);
    end
    tick(); #1;
    chk("tb_fvalid_c3", {31'b0, fetchValidF}, 32'h1);
    fetchReqF = 1'b0;
    for (int c = 4; c <= 5; c++) begin
      tick(); #1;
      chk_port("tb_m", 1'b1, 32'h3C);
    end
    tick(); #1;
    chk("tb_mvalid_c6", {31'b0, memValidM}, 32'h1);
    memReqM = 1'b0;
    tick();

    // Write: memRdataM keeps the previous read value
    tick();
    memReqM = 1'b1; memWriteM = 1'b1; memAddrM = 32'h40; memWdataM = 32'h1234;
    mq.push_back(last_mrd);
    for (int c = 1; c <= 2; c++) begin
      tick(); #1;
      chk_port("wr", 1'b1, 32'h40);
      chk("wr_we", {31'b0, portWe}, 32'h1);
      chk("wr_wdata", portWdata, 32'h1234);
    end
    tick(); #1;
    chk("wr_mvalid_c3", {31'b0, memValidM}, 32'h1);
    chk("wr_rdata_kept", memRdataM, last_mrd);
    chk("wr_we_c3", {31'b0, portWe}, 32'h0);
    memReqM = 1'b0; memWriteM = 1'b0;
    tick();

    // Reset in cycle 1 of an M read: abandoned, then restarted
    tick();
    memReqM = 1'b1; memAddrM = 32'h50; mq.push_back(rd_model(32'h50));
    tick(); #1;
    chk_port("mr_c1", 1'b1, 32'h50);
    rst = 1'b1;
    tick();
    rst = 1'b0; last_mrd = '0;
    #1;
    chk("mr_state_c2", {30'b0, dut.state_q}, {30'b0, IDLE});
    chk_port("mr_c2", 1'b0, 32'h0);
    chk("mr_mvalid_c2", {31'b0, memValidM}, 32'h0);
    chk("mr_mdata_c2", memRdataM, 32'h0);
    chk("mr_fdata_c2", fetchDataF, 32'h0);
    chk("mr_stallM_c2", {31'b0, stallM}, 32'h1);
    for (int c = 3; c <= 4; c++) begin
      tick(); #1;
      chk_port("mr_restart", 1'b1, 32'h50);
      chk("mr_no_valid", {31'b0, memValidM}, 32'h0);
    end
    tick(); #1;
    chk("mr_mvalid_c5", {31'b0, memValidM}, 32'h1);
    chk("mr_mdata_c5", memRdataM, rd_model(32'h50));
    memReqM = 1'b0;

    repeat (3) tick();
    chk("fq_drained", fq.size(), 32'd0);
    chk("mq_drained", mq.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
